// File: rtl/tlb_walk_arbiter.sv
// tlb_walk_arbiter
//   Shares one page-table walker between the ITLB and DTLB and sequences
//   SFENCE.VMA flushes so that a flush never overlaps a walk.
//   Ports:
//     clk_i, rst_i                     clock, synchronous active-high reset
//     i_req_i/i_vaddr_i                ITLB miss (level, held until i_resp_o)
//     d_req_i/d_vaddr_i/d_is_store_i   DTLB miss (level, held until d_resp_o)
//     fence_req_i/fence_va_i/_asid_i   SFENCE.VMA request, held until fence_ack_o
//     walk_req_o + walk_vaddr_o/...    walker start pulse and registered request
//     walk_done_i/fault_i/pte_i        walker completion
//     i_resp_o/d_resp_o/resp_*_o       registered response pulse and payload
//     tlb_flush_o/flush_*_o/fence_ack_o  flush pulse with latched va/asid
//     busy_o                           arbiter not idle
module tlb_walk_arbiter #(
  parameter int VADDR_W = 32,
  parameter int PTE_W   = 32,
  parameter int ASID_W  = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_req_i,
  input  logic [VADDR_W-1:0] i_vaddr_i,
  input  logic               d_req_i,
  input  logic [VADDR_W-1:0] d_vaddr_i,
  input  logic               d_is_store_i,
  input  logic               fence_req_i,
  input  logic [VADDR_W-1:0] fence_va_i,
  input  logic [ASID_W-1:0]  fence_asid_i,
  output logic               walk_req_o,
  output logic [VADDR_W-1:0] walk_vaddr_o,
  output logic               walk_is_instr_o,
  output logic               walk_is_store_o,
  input  logic               walk_done_i,
  input  logic               walk_fault_i,
  input  logic [PTE_W-1:0]   walk_pte_i,
  output logic               i_resp_o,
  output logic               d_resp_o,
  output logic               resp_fault_o,
  output logic [PTE_W-1:0]   resp_pte_o,
  output logic               tlb_flush_o,
  output logic [VADDR_W-1:0] flush_va_o,
  output logic [ASID_W-1:0]  flush_asid_o,
  output logic               fence_ack_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, WALK_I, WALK_D, FLUSH} state_e;

  state_e             state_q, state_d;
  logic               done_q;      // WALK_x cycle after walk_done: the response slot
  logic               abort_q;     // owner dropped its req at some point in the walk
  logic               last_d_q;    // last grant went to DTLB (reset: ITLB)
  logic               i_resp_q, d_resp_q, resp_fault_q;
  logic [PTE_W-1:0]   resp_pte_q;
  logic [VADDR_W-1:0] walk_vaddr_q, flush_va_q;
  logic [ASID_W-1:0]  flush_asid_q;
  logic               walk_is_instr_q, walk_is_store_q;

  logic grant_i, grant_d, in_walk, owner_req, walk_fin;

  // Round-robin: with both pending, the side not granted last wins.
  assign grant_i   = (state_q == IDLE) && !fence_req_i && i_req_i && (!d_req_i || last_d_q);
  assign grant_d   = (state_q == IDLE) && !fence_req_i && d_req_i && (!i_req_i || !last_d_q);
  assign in_walk   = ((state_q == WALK_I) || (state_q == WALK_D)) && !done_q;
  assign owner_req = (state_q == WALK_I) ? i_req_i : d_req_i;
  // walk_done outside an active walk (IDLE, FLUSH, response slot) is ignored.
  assign walk_fin  = in_walk && walk_done_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fence_req_i)  state_d = FLUSH;
        else if (grant_i) state_d = WALK_I;
        else if (grant_d) state_d = WALK_D;
      end
      WALK_I, WALK_D: begin
        // A fence that arrived during the walk goes straight after the response.
        if (done_q) state_d = fence_req_i ? FLUSH : IDLE;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    walk_req_o  = grant_i || grant_d;
    tlb_flush_o = (state_q == FLUSH);
    fence_ack_o = (state_q == FLUSH);
    busy_o      = (state_q != IDLE);
  end

  // Datapath and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q          <= 1'b0;
      abort_q         <= 1'b0;
      last_d_q        <= 1'b0;
      i_resp_q        <= 1'b0;
      d_resp_q        <= 1'b0;
      resp_fault_q    <= 1'b0;
      resp_pte_q      <= '0;
      walk_vaddr_q    <= '0;
      walk_is_instr_q <= 1'b0;
      walk_is_store_q <= 1'b0;
      flush_va_q      <= '0;
      flush_asid_q    <= '0;
    end else begin
      done_q   <= walk_fin;
      i_resp_q <= walk_fin && (state_q == WALK_I) && !abort_q && owner_req;
      d_resp_q <= walk_fin && (state_q == WALK_D) && !abort_q && owner_req;
      if (walk_fin) begin
        resp_pte_q   <= walk_pte_i;
        resp_fault_q <= walk_fault_i;
      end
      if (grant_i || grant_d) begin
        abort_q         <= 1'b0;
        last_d_q        <= grant_d;
        walk_vaddr_q    <= grant_d ? d_vaddr_i : i_vaddr_i;
        walk_is_instr_q <= grant_i;
        walk_is_store_q <= grant_d && d_is_store_i;
      end else if (in_walk && !owner_req) begin
        abort_q <= 1'b1;
      end
      if ((state_d == FLUSH) && (state_q != FLUSH)) begin
        flush_va_q   <= fence_va_i;
        flush_asid_q <= fence_asid_i;
      end
    end
  end

  assign i_resp_o        = i_resp_q;
  assign d_resp_o        = d_resp_q;
  assign resp_fault_o    = resp_fault_q;
  assign resp_pte_o      = resp_pte_q;
  assign walk_vaddr_o    = walk_vaddr_q;
  assign walk_is_instr_o = walk_is_instr_q;
  assign walk_is_store_o = walk_is_store_q;
  assign flush_va_o      = flush_va_q;
  assign flush_asid_o    = flush_asid_q;

endmodule

// File: tb/tb_tlb_walk_arbiter.sv
module tb_tlb_walk_arbiter;
  localparam int VADDR_W = 32, PTE_W = 32, ASID_W = 9;

  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 0, d_req = 0, d_is_store = 0, fence_req = 0;
  logic [VADDR_W-1:0] i_vaddr = '0, d_vaddr = '0, fence_va = '0;
  logic [ASID_W-1:0]  fence_asid = '0;
  logic walk_done = 0, walk_fault = 0;
  logic [PTE_W-1:0] walk_pte = '0;
  logic walk_req, walk_is_instr, walk_is_store, i_resp, d_resp, resp_fault;
  logic tlb_flush, fence_ack, busy;
  logic [VADDR_W-1:0] walk_vaddr, flush_va;
  logic [ASID_W-1:0]  flush_asid;
  logic [PTE_W-1:0]   resp_pte;

  always #5 clk = ~clk;

  tlb_walk_arbiter #(.VADDR_W(VADDR_W), .PTE_W(PTE_W), .ASID_W(ASID_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req), .i_vaddr_i(i_vaddr),
    .d_req_i(d_req), .d_vaddr_i(d_vaddr), .d_is_store_i(d_is_store),
    .fence_req_i(fence_req), .fence_va_i(fence_va), .fence_asid_i(fence_asid),
    .walk_req_o(walk_req), .walk_vaddr_o(walk_vaddr),
    .walk_is_instr_o(walk_is_instr), .walk_is_store_o(walk_is_store),
    .walk_done_i(walk_done), .walk_fault_i(walk_fault), .walk_pte_i(walk_pte),
    .i_resp_o(i_resp), .d_resp_o(d_resp), .resp_fault_o(resp_fault), .resp_pte_o(resp_pte),
    .tlb_flush_o(tlb_flush), .flush_va_o(flush_va), .flush_asid_o(flush_asid),
    .fence_ack_o(fence_ack), .busy_o(busy)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected responses
  typedef struct packed { logic is_d; logic [PTE_W-1:0] pte; logic fault; } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (i_resp || d_resp) begin
      if (sb.size() == 0) chk("unexpected_resp", {i_resp, d_resp}, 2'b00);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_is_d", {i_resp, d_resp}, e.is_d ? 2'b01 : 2'b10);
        chk("sb_pte", resp_pte, e.pte);
        chk("sb_fault", resp_fault, e.fault);
      end
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask

  typedef struct {
    logic ireq, dreq, store, fault, exp_d;
    logic [VADDR_W-1:0] iva, dva;
    logic [PTE_W-1:0] pte;
    int dly;
  } vec_t;
  vec_t vecs[10];

  // Grant at t, walk_done at t+dly, response at t+dly+1; granted side drops its req.
  task automatic run_vec(input vec_t v);
    i_req = v.ireq; d_req = v.dreq; i_vaddr = v.iva; d_vaddr = v.dva; d_is_store = v.store;
    @(negedge clk);
    chk("walk_req_at_t", walk_req, 1'b1);
    cyc();
    for (int c = 1; c < v.dly; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("walk_vaddr", walk_vaddr, v.exp_d ? v.dva : v.iva);
        chk("walk_is_instr", walk_is_instr, !v.exp_d);
        chk("walk_is_store", walk_is_store, v.exp_d && v.store);
        chk("busy_walk", busy, 1'b1);
      end
      chk("no_walk_req_in_walk", walk_req, 1'b0);
      cyc();
    end
    walk_done = 1; walk_pte = v.pte; walk_fault = v.fault;
    sb.push_back('{is_d: v.exp_d, pte: v.pte, fault: v.fault});
    cyc();
    walk_done = 0;
    @(negedge clk);
    chk("resp_at_u1", v.exp_d ? d_resp : i_resp, 1'b1);
    chk("busy_resp_slot", busy, 1'b1);
    if (v.exp_d) d_req = 0; else i_req = 0;
    cyc();
  endtask

  initial begin
    // Both pending: strict alternation starting with D (last_grant=I after reset)
    for (int k = 0; k < 8; k++)
      vecs[k] = '{ireq: 1, dreq: 1, store: k[1], fault: k[0], exp_d: !k[0],
                  iva: 32'h1000_0000 + k * 32'h1000, dva: 32'h4000_0000 + k * 32'h10,
                  pte: 32'hA000_0000 | k, dly: 2 + k % 3};
    vecs[8] = '{ireq: 0, dreq: 1, store: 1, fault: 0, exp_d: 1,
                iva: 32'h0, dva: 32'h8000_1000, pte: 32'h2000_00CF, dly: 5};
    vecs[9] = '{ireq: 1, dreq: 0, store: 1, fault: 1, exp_d: 0,
                iva: 32'h0000_3000, dva: 32'h0, pte: 32'h0000_0001, dly: 3};

    cyc(); cyc();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {walk_req, i_resp, d_resp, tlb_flush, fence_ack}, 5'b0);
    chk("rst_regs", {walk_vaddr, resp_pte}, 64'h0);
    chk("rst_flush", {flush_va, flush_asid}, 41'h0);
    rst = 0;
    cyc();

    foreach (vecs[k]) run_vec(vecs[k]);
    i_req = 0; d_req = 0;
    @(negedge clk);
    chk("idle_after_table", busy, 0);
    cyc();

    // Abort: d_req dropped 2 cycles into the walk, faulting walk_done -> no response
    d_req = 1; d_vaddr = 32'h5000_0000; d_is_store = 0;
    @(negedge clk); chk("abort_grant", walk_req, 1);
    cyc(); cyc();
    d_req = 0;
    cyc(); cyc();
    walk_done = 1; walk_fault = 1; walk_pte = 32'hDEAD_BEEF;
    cyc(); walk_done = 0;
    @(negedge clk);
    chk("abort_no_resp", {i_resp, d_resp}, 2'b00);
    chk("abort_busy_slot", busy, 1);
    cyc();
    @(negedge clk); chk("abort_busy_fall", busy, 0);
    cyc();

    // Fence mid WALK_I: i_resp, then flush next cycle, then pending d_req
    i_req = 1; i_vaddr = 32'h0000_7000;
    @(negedge clk); chk("fence_i_grant", walk_req, 1);
    cyc(); cyc();
    fence_req = 1; fence_va = '0; fence_asid = 9'd3; d_req = 1; d_vaddr = 32'h6000_0000;
    cyc();
    walk_done = 1; walk_fault = 0; walk_pte = 32'h1234_5678;
    sb.push_back('{is_d: 0, pte: 32'h1234_5678, fault: 0});
    cyc(); walk_done = 0;
    @(negedge clk);
    chk("fence_i_resp", i_resp, 1);
    chk("fence_not_yet", tlb_flush, 0);
    i_req = 0;
    cyc();
    @(negedge clk);
    chk("fence_flush", {tlb_flush, fence_ack}, 2'b11);
    chk("fence_asid", flush_asid, 9'd3);
    chk("fence_va", flush_va, 0);
    chk("fence_no_grant", walk_req, 0);
    fence_req = 0;
    cyc();
    @(negedge clk); chk("fence_then_d_grant", walk_req, 1);
    cyc();
    @(negedge clk); chk("fence_d_vaddr", walk_vaddr, 32'h6000_0000);
    walk_done = 1; walk_pte = 32'h0BAD_F00D;
    sb.push_back('{is_d: 1, pte: 32'h0BAD_F00D, fault: 0});
    cyc(); walk_done = 0;
    @(negedge clk); chk("fence_d_resp", d_resp, 1);
    d_req = 0;
    cyc(); cyc();

    // Reset during WALK_D: outputs back to reset values, later walk_done ignored
    d_req = 1; d_vaddr = 32'h7000_0000; d_is_store = 1;
    @(negedge clk); chk("rstwalk_grant", walk_req, 1);
    cyc(); cyc();
    rst = 1; d_req = 0;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rstwalk_busy", busy, 0);
    chk("rstwalk_regs", {walk_vaddr, resp_pte}, 64'h0);
    chk("rstwalk_bits", {walk_is_store, walk_is_instr, tlb_flush, i_resp, d_resp}, 5'b0);
    chk("rstwalk_flush", {flush_va, flush_asid}, 41'h0);
    walk_done = 1; walk_pte = 32'hFFFF_FFFF;
    cyc(); walk_done = 0;
    @(negedge clk);
    chk("idle_done_no_resp", {i_resp, d_resp}, 2'b00);
    chk("idle_done_busy", busy, 0);
    cyc();

    // last_grant reset to I: both pending -> D first
    i_req = 1; d_req = 1; i_vaddr = 32'h100; d_vaddr = 32'h200; d_is_store = 0;
    @(negedge clk); chk("rr_after_rst", walk_req, 1);
    cyc();
    @(negedge clk); chk("rr_after_rst_d", walk_is_instr, 0);
    walk_done = 1; walk_pte = 32'h77;
    sb.push_back('{is_d: 1, pte: 32'h77, fault: 0});
    cyc(); walk_done = 0; d_req = 0; i_req = 0;
    cyc(); cyc();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
